// File: rtl/control_unit.sv
// Instruction sequencer: latches the fetched instruction, decodes it and
// steps the register-file, ALU and data-memory strobes, then retires it with
// FETCH_INC_PC. Also owns the WAIT delay counter and the terminal HALT state.

package cpu_common;
  typedef enum logic [1:0] {
    FETCH_NOP    = 2'd0,
    FETCH_INC_PC = 2'd1
  } fetch_operation_t;
endpackage

module control_unit
  import cpu_common::*;
(
  input  logic             clk,
  input  logic             rst_async,
  input  logic             fetch_complete,
  input  logic [15:0]      inst,
  output fetch_operation_t fetch_operation,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic [2:0]       rf_waddr,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  output logic [2:0]       alu_op,
  output logic [7:0]       imm,
  output logic             mem_data_re,
  output logic             mem_data_we,
  output logic             halted,
  output logic             illegal_inst
);

  typedef enum logic [2:0] {
    StWaitFetch, StExec, StMemWait, StDelay, StSettle, StHalted
  } state_e;

  localparam logic [2:0] ClsNop   = 3'd0;
  localparam logic [2:0] ClsMov   = 3'd1;
  localparam logic [2:0] ClsAlu   = 3'd2;
  localparam logic [2:0] ClsLoad  = 3'd3;
  localparam logic [2:0] ClsStore = 3'd4;
  localparam logic [2:0] ClsWait  = 3'd5;
  localparam logic [2:0] ClsHalt  = 3'd6;
  localparam logic [2:0] ClsIll   = 3'd7;

  localparam logic [1:0] WselImm = 2'd0;
  localparam logic [1:0] WselAlu = 2'd1;
  localparam logic [1:0] WselMem = 2'd2;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [7:0]       cnt_q, cnt_d;
  fetch_operation_t fetch_op_q, fetch_op_d;
  logic             rf_we_q, rf_we_d;
  logic [1:0]       rf_wsel_q, rf_wsel_d;
  logic             mem_re_q, mem_re_d;
  logic             mem_we_q, mem_we_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;

  // Class 111 is always illegal; otherwise the length bit must match the class.
  function automatic logic inst_legal(input logic [15:0] i);
    logic ok;
    case (i[4:2])
      ClsMov, ClsAlu, ClsWait: ok = i[1];
      ClsIll:                  ok = 1'b0;
      default:                 ok = !i[1];
    endcase
    return ok;
  endfunction

  // Next state, instruction register and delay counter.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWaitFetch: begin
        if (fetch_complete) begin
          ir_d    = inst;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StSettle;
        if (inst_legal(ir_q)) begin
          unique case (ir_q[4:2])
            ClsLoad: state_d = StMemWait;
            ClsWait: begin
              cnt_d = ir_q[15:8];
              if (ir_q[15:8] != 8'd0) state_d = StDelay;
            end
            ClsHalt: state_d = StHalted;
            default: ;
          endcase
        end
      end
      StMemWait: state_d = StSettle;
      StDelay: begin
        // Counter saturates at zero; the exit on <= 1 also guards a stray zero.
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = StSettle;
      end
      // Fetch still shows fetch_complete for the old instruction here.
      StSettle: state_d = StWaitFetch;
      StHalted: ;
      default:  state_d = StWaitFetch;
    endcase
  end

  // Strobes decoded from the next state so they register in step with it.
  always_comb begin
    fetch_op_d = FETCH_NOP;
    rf_we_d    = 1'b0;
    rf_wsel_d  = WselImm;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    halted_d   = 1'b0;
    illegal_d  = 1'b0;
    unique case (state_d)
      StExec: begin
        if (!inst_legal(ir_d)) begin
          illegal_d  = 1'b1;
          fetch_op_d = FETCH_INC_PC;
        end else begin
          unique case (ir_d[4:2])
            ClsNop: fetch_op_d = FETCH_INC_PC;
            ClsMov: begin
              rf_we_d    = 1'b1;
              rf_wsel_d  = WselImm;
              fetch_op_d = FETCH_INC_PC;
            end
            ClsAlu: begin
              rf_we_d    = 1'b1;
              rf_wsel_d  = WselAlu;
              fetch_op_d = FETCH_INC_PC;
            end
            ClsLoad: mem_re_d = 1'b1;
            ClsStore: begin
              mem_we_d   = 1'b1;
              fetch_op_d = FETCH_INC_PC;
            end
            ClsWait: if (ir_d[15:8] == 8'd0) fetch_op_d = FETCH_INC_PC;
            default: ;
          endcase
        end
      end
      StMemWait: begin
        rf_we_d    = 1'b1;
        rf_wsel_d  = WselMem;
        fetch_op_d = FETCH_INC_PC;
      end
      StDelay:  if (cnt_d == 8'd1) fetch_op_d = FETCH_INC_PC;
      StHalted: halted_d = 1'b1;
      default:  ;
    endcase
  end

  // Single state register; reset clears state and outputs immediately.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q    <= StWaitFetch;
      ir_q       <= 16'd0;
      cnt_q      <= 8'd0;
      fetch_op_q <= FETCH_NOP;
      rf_we_q    <= 1'b0;
      rf_wsel_q  <= WselImm;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      fetch_op_q <= fetch_op_d;
      rf_we_q    <= rf_we_d;
      rf_wsel_q  <= rf_wsel_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign fetch_operation = fetch_op_q;
  assign rf_we           = rf_we_q;
  assign rf_wsel         = rf_wsel_q;
  assign mem_data_re     = mem_re_q;
  assign mem_data_we     = mem_we_q;
  assign halted          = halted_q;
  assign illegal_inst    = illegal_q;

  // Field outputs track the instruction register directly.
  assign rf_waddr   = ir_q[7:5];
  assign rf_raddr_a = ir_q[7:5];
  assign rf_raddr_b = ir_q[13:11];
  assign alu_op     = ir_q[10:8];
  assign imm        = ir_q[15:8];

  // Bit 0 carries no meaning for this block.
  logic unused_ir0;
  assign unused_ir0 = ir_q[0];

endmodule
